// File: rtl/muldiv_sched_pkg.sv
// Shared op codes, FSM states and unit select for the EX-stage mult/div scheduler.
package muldiv_sched_pkg;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef enum logic {
    UNIT_MUL = 1'b0,
    UNIT_DIV = 1'b1
  } unit_t;

  function automatic unit_t op_unit(input logic [1:0] op);
    return (op == MD_DIVU || op == MD_DIV) ? UNIT_DIV : UNIT_MUL;
  endfunction

  function automatic logic op_signed(input logic [1:0] op);
    return (op == MD_MULT || op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// Cycle counter for the scheduler's BUSY/DRAIN residency; expire fires on the TIMEOUT-th enabled cycle.
module muldiv_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = en && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/muldiv_sched.sv
// EX-stage mult/div scheduler: 1-cycle launch, unit latency, 1 DONE cycle held while stall_ext is high.
// Optional DIV_ZERO_FAST_EN: DIV/DIVU by zero skips the divider and completes straight to DONE.
module muldiv_sched
  import muldiv_sched_pkg::*;
#(
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           op_valid,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           stall_ext,
  input  logic           flush,
  output logic           mul_opn_valid,
  output logic           mul_sign,
  input  logic           mul_res_valid,
  output logic           mul_res_ready,
  input  logic [2*W-1:0] mul_result,
  output logic           div_opn_valid,
  output logic           div_sign,
  input  logic           div_res_valid,
  output logic           div_res_ready,
  input  logic [2*W-1:0] div_result,
  output logic [W-1:0]   op_a,
  output logic [W-1:0]   op_b,
  output logic [2*W-1:0] result,
  output logic           busy_stall,
  output logic           hilo_we,
  output logic           err_timeout
);

  state_t         state_q, state_d;
  unit_t          unit_q, unit_d;
  logic           sign_q, sign_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic [2*W-1:0] result_q, result_d;
  logic           err_q, err_d;

  logic           opn_fire;
  logic           res_rdy;
  logic           fast_zero;
  logic           wd_en;
  logic           wd_expire;
  logic           res_vld_sel;
  logic [2*W-1:0] res_dat_sel;
  unit_t          unit_out;
  logic           sign_out;

`ifdef DIV_ZERO_FAST_EN
  assign fast_zero = (op_unit(op) == UNIT_DIV) && (b == '0);
`else
  assign fast_zero = 1'b0;
`endif

  assign res_vld_sel = (unit_q == UNIT_DIV) ? div_res_valid : mul_res_valid;
  assign res_dat_sel = (unit_q == UNIT_DIV) ? div_result : mul_result;
  assign wd_en       = (state_q == ST_BUSY) || (state_q == ST_DRAIN);

  muldiv_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (!wd_en),
    .en     (wd_en),
    .expire (wd_expire)
  );

  always_comb begin
    state_d    = state_q;
    unit_d     = unit_q;
    sign_d     = sign_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    result_d   = result_q;
    err_d      = err_q;
    busy_stall = 1'b0;
    hilo_we    = 1'b0;
    opn_fire   = 1'b0;
    res_rdy    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (op_valid && !flush) begin
          busy_stall = 1'b1;
          unit_d     = op_unit(op);
          sign_d     = op_signed(op);
          op_a_d     = a;
          op_b_d     = b;
          if (fast_zero) begin
            result_d = {a, {W{1'b1}}};
            state_d  = ST_DONE;
          end else begin
            opn_fire = 1'b1;
            state_d  = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        busy_stall = 1'b1;
        res_rdy    = 1'b1;
        // A result landing in the flush cycle is accepted from the unit but never committed.
        if (res_vld_sel) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            result_d = res_dat_sel;
            state_d  = ST_DONE;
          end
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (!stall_ext) begin
          hilo_we = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        busy_stall = 1'b1;
        res_rdy    = 1'b1;
        if (res_vld_sel) begin
          state_d = ST_IDLE;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operands/sign pass straight through on the launch cycle so the unit sees them with opn_valid.
  assign unit_out      = opn_fire ? op_unit(op) : unit_q;
  assign sign_out      = opn_fire ? op_signed(op) : sign_q;
  assign op_a          = opn_fire ? a : op_a_q;
  assign op_b          = opn_fire ? b : op_b_q;

  assign mul_opn_valid = opn_fire && (unit_out == UNIT_MUL);
  assign div_opn_valid = opn_fire && (unit_out == UNIT_DIV);
  assign mul_sign      = sign_out && (unit_out == UNIT_MUL);
  assign div_sign      = sign_out && (unit_out == UNIT_DIV);
  assign mul_res_ready = res_rdy && (unit_q == UNIT_MUL);
  assign div_res_ready = res_rdy && (unit_q == UNIT_DIV);

  assign result        = result_q;
  assign err_timeout   = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      unit_q   <= UNIT_MUL;
      sign_q   <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      unit_q   <= unit_d;
      sign_q   <= sign_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Randomized scoreboard bench for muldiv_sched with behavioural mult/div unit stubs.
module tb_muldiv_sched;

  localparam int W       = 32;
  localparam int TIMEOUT = 64;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  logic           clk, rst;
  logic           op_valid;
  logic [1:0]     op;
  logic [W-1:0]   a, b;
  logic           stall_ext, flush;
  logic           mul_opn_valid, mul_sign, mul_res_valid, mul_res_ready;
  logic [2*W-1:0] mul_result;
  logic           div_opn_valid, div_sign, div_res_valid, div_res_ready;
  logic [2*W-1:0] div_result;
  logic [W-1:0]   op_a, op_b;
  logic [2*W-1:0] result;
  logic           busy_stall, hilo_we, err_timeout;

  int checks = 0;
  int errors = 0;
  int mul_lat = 1;
  int div_lat = 1;
  logic [2*W-1:0] exp_q[$];

  muldiv_sched #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .a(a), .b(b),
    .stall_ext(stall_ext), .flush(flush),
    .mul_opn_valid(mul_opn_valid), .mul_sign(mul_sign), .mul_res_valid(mul_res_valid),
    .mul_res_ready(mul_res_ready), .mul_result(mul_result),
    .div_opn_valid(div_opn_valid), .div_sign(div_sign), .div_res_valid(div_res_valid),
    .div_res_ready(div_res_ready), .div_result(div_result),
    .op_a(op_a), .op_b(op_b), .result(result), .busy_stall(busy_stall),
    .hilo_we(hilo_we), .err_timeout(err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {hi,lo}: product, or {remainder, quotient}; divide by zero yields {dividend, all ones}.
  function automatic logic [2*W-1:0] unit_calc(input bit isdiv, input bit sgn,
                                               input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] xe, ye;
    logic [W-1:0]   ax, ay, q, r;
    bit             nx, ny;
    if (!isdiv) begin
      xe = sgn ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
      ye = sgn ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
      return xe * ye;
    end
    if (y == '0) return {x, {W{1'b1}}};
    nx = sgn && x[W-1];
    ny = sgn && y[W-1];
    ax = nx ? -x : x;
    ay = ny ? -y : y;
    q  = ax / ay;
    r  = ax % ay;
    if (nx != ny) q = -q;
    if (nx) r = -r;
    return {r, q};
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  initial begin : mul_stub
    logic [2*W-1:0] r;
    int n, guard;
    mul_res_valid = 1'b0;
    mul_result    = '0;
    forever begin
      @(negedge clk);
      if (mul_opn_valid && !rst) begin
        r = unit_calc(1'b0, mul_sign, op_a, op_b);
        n = mul_lat;
        if (n > 0) begin
          repeat (n) @(posedge clk);
          #1;
          mul_res_valid = 1'b1;
          mul_result    = r;
          guard = 0;
          do begin
            @(negedge clk);
            guard++;
          end while (!mul_res_ready && guard < 200);
          @(posedge clk);
          #1;
          mul_res_valid = 1'b0;
          mul_result    = '0;
        end
      end
    end
  end

  initial begin : div_stub
    logic [2*W-1:0] r;
    int n, guard;
    div_res_valid = 1'b0;
    div_result    = '0;
    forever begin
      @(negedge clk);
      if (div_opn_valid && !rst) begin
        r = unit_calc(1'b1, div_sign, op_a, op_b);
        n = div_lat;
        if (n > 0) begin
          repeat (n) @(posedge clk);
          #1;
          div_res_valid = 1'b1;
          div_result    = r;
          guard = 0;
          do begin
            @(negedge clk);
            guard++;
          end while (!div_res_ready && guard < 200);
          @(posedge clk);
          #1;
          div_res_valid = 1'b0;
          div_result    = '0;
        end
      end
    end
  end

  // Scoreboard monitor: every HI/LO write must match the oldest committed expectation.
  always @(negedge clk) begin
    if (!rst) begin
      check("handshake_exclusive",
            {mul_opn_valid & div_opn_valid, mul_res_ready & div_res_ready}, '0);
      if (hilo_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_hilo_we result=%h required=no write", result);
        end else begin
          check("commit_result", result, exp_q.pop_front());
        end
      end
    end
  end

  function automatic bit is_fast(input logic [1:0] o, input logic [W-1:0] bb);
`ifdef DIV_ZERO_FAST_EN
    return o[1] && (bb == '0);
`else
    return 1'b0;
`endif
  endfunction

  // One EX instruction: flush_at>0 flushes in that BUSY cycle, flush_done flushes in DONE after nstall stalls.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input int lat, input int flush_at, input int nstall, input bit flush_done);
    logic [2*W-1:0] exp_r;
    bit isdiv, fast, fin, draining;
    int c, stalls, done_seen, exp_stall;
    isdiv     = o[1];
    fast      = is_fast(o, bb);
    exp_r     = unit_calc(o[1], o[0], aa, bb);
    exp_stall = fast ? 1 : lat + 1;
    if (isdiv) div_lat = lat; else mul_lat = lat;
    if (flush_at < 0 && !flush_done) exp_q.push_back(exp_r);
    fin = 0; draining = 0; c = 0; stalls = 0; done_seen = 0;
    @(posedge clk);
    #1;
    op_valid  = 1'b1;
    op        = o;
    a         = aa;
    b         = bb;
    flush     = 1'b0;
    stall_ext = (nstall > 0) || flush_done;
    while (!fin && c < 400) begin
      @(negedge clk);
      if (c == 0) begin
        check("launch_vld", {mul_opn_valid, div_opn_valid}, {!isdiv, isdiv && !fast});
        if (!fast) begin
          check("launch_opnd", {op_a, op_b}, {aa, bb});
          check("launch_sign", isdiv ? div_sign : mul_sign, o[0]);
        end
      end
      if (busy_stall) stalls++;
      if (flush || draining) begin
        draining = 1;
        if (flush && !busy_stall) check("flush_done_no_we", hilo_we, 0);
        if (!busy_stall || (isdiv ? div_res_valid : mul_res_valid)) fin = 1;
      end else if (!busy_stall && c > 0) begin
        if (!stall_ext) begin
          check("commit_we", hilo_we, 1);
          check("stall_cycles", stalls, exp_stall);
          fin = 1;
        end else begin
          check("hold_we", hilo_we, 0);
          check("hold_result", result, exp_r);
          done_seen++;
        end
      end
      c++;
      if (!fin) begin
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (draining) begin
          op_valid = 1'b0;
        end else if (flush_at == c) begin
          flush = 1'b1;
        end else if (flush_done && done_seen > 0 && done_seen >= nstall) begin
          flush     = 1'b1;
          stall_ext = 1'b0;
        end else begin
          stall_ext = (done_seen < nstall) || flush_done;
        end
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL op_timeout op=%0d cycles=%0d required=completion", o, c);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      op_valid  = 1'b0;
      flush     = 1'b0;
      stall_ext = 1'($urandom_range(0, 1));
      a         = $urandom;
      b         = $urandom;
      @(negedge clk);
      check("idle_quiet", {busy_stall, hilo_we, mul_opn_valid, div_opn_valid}, '0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1; op_valid = 1'b0; op = '0; a = '0; b = '0; stall_ext = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {mul_opn_valid, mul_sign, mul_res_ready, div_opn_valid, div_sign,
                       div_res_ready, busy_stall, hilo_we, err_timeout}, '0);
    check("rst_opnd", {op_a, op_b}, '0);
    check("rst_result", result, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, 4, -1, 0, 0);
    run_op(OP_DIVU, 32'd100, 32'd7, 3, -1, 3, 0);
    run_op(OP_DIV, 32'hFFFFFF9C, 32'd7, 5, 2, 0, 0);
    run_op(OP_MULTU, 32'hDEADBEEF, 32'h12345678, 2, -1, 0, 0);
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, -1, 0, 1);
    run_op(OP_DIVU, 32'd1000, 32'd9, 3, 3, 0, 0);
    idle(1);
    run_op(OP_DIV, 32'd5, 32'd0, 3, -1, 0, 0);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1, -1, 1, 0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]   o;
      logic [W-1:0] x, y;
      int lat, mode;
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) y = W'($urandom_range(0, 9));
      if (o == OP_DIV && x == 32'h80000000 && y == 32'hFFFFFFFF) y = 32'd1;
      lat  = $urandom_range(1, 6);
      mode = $urandom_range(0, 2);
      if (is_fast(o, y) && mode == 1) mode = 0;
      case (mode)
        0:       run_op(o, x, y, lat, -1, $urandom_range(0, 3), 0);
        1:       run_op(o, x, y, lat, $urandom_range(1, lat), 0, 0);
        default: run_op(o, x, y, lat, -1, $urandom_range(0, 2), 1);
      endcase
      idle($urandom_range(0, 2));
    end
    idle(2);
    check("scoreboard_drained", exp_q.size(), 0);

    mul_lat = -1;
    @(posedge clk);
    #1;
    op_valid = 1'b1; op = OP_MULTU; a = 32'd7; b = 32'd9; stall_ext = 1'b0; flush = 1'b0;
    repeat (TIMEOUT + 1) @(negedge clk);
    check("wd_before_expire", {busy_stall, err_timeout}, 2'b10);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    @(negedge clk);
    check("wd_expired_idle", {busy_stall, err_timeout}, 2'b01);
    idle(3);
    check("wd_sticky", err_timeout, 1);

    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst2_err_clear", {err_timeout, busy_stall}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mul_lat = 1;
    run_op(OP_MULT, 32'h80000000, 32'h80000000, 3, -1, 1, 0);
    idle(2);
    check("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
